// File: rtl/width_combin_arb_pkg.sv
// Shared types and constants for the packet-level arbiter in front of the
// narrow-to-wide packer.
package width_combin_pkg;

    typedef enum logic {IDLE, XFER} arb_state_t;

    // Width of the per-grant beat counter.
    localparam int BSIZE = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/width_combin_arb_rr_arbiter.sv
// Combinational round-robin pick: the first set request found scanning
// upward from ptr+1, wrapping around at N.
module rr_arbiter
    import width_combin_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int i = 1; i <= N; i++) begin
            // Offset from the last winner, folded back into 0..N-1.
            sum = {1'b0, ptr} + (IW + 1)'(i);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/width_combin_arb.sv
// Packet-level round-robin arbiter: holds a grant from the first beat to the
// source's last beat (or the burst limit) so packed words never mix packets.
module width_combin_arb
    import width_combin_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int DSIZE = 8,
    parameter  int BURST = 0,
    localparam int CSIZE = clog2(NCH)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NCH*DSIZE-1:0] req_data,
    input  logic [NCH-1:0]       req_vld,
    input  logic [NCH-1:0]       req_last,
    output logic [NCH-1:0]       req_ready,
    output logic [DSIZE-1:0]     out_data,
    output logic                 out_vld,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 out_align_last,
    output logic [CSIZE-1:0]     out_chan,
    output logic                 busy
);

    localparam logic [BSIZE-1:0] BURST_LAST = BSIZE'((BURST > 0) ? BURST - 1 : 0);
    localparam logic [BSIZE-1:0] CNT_MAX    = '1;
    localparam logic [CSIZE-1:0] PTR_RST    = CSIZE'(NCH - 1);

    arb_state_t       state_q, state_d;
    logic [CSIZE-1:0] chan_q, chan_d;
    logic [CSIZE-1:0] ptr_q, ptr_d;
    logic [BSIZE-1:0] cnt_q, cnt_d;

    logic [NCH-1:0]   gnt_onehot;
    logic [CSIZE-1:0] gnt_idx;

    logic             xfer;
    logic             g_vld;
    logic             g_last;
    logic [DSIZE-1:0] g_data;
    logic             term;
    logic             hs;

    rr_arbiter #(.N(NCH)) u_rr (
        .req        (req_vld),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    // Datapath mux from the granted channel; out_vld never looks at out_ready.
    always_comb begin
        xfer           = (state_q == XFER);
        g_vld          = req_vld[chan_q];
        g_last         = req_last[chan_q];
        g_data         = req_data[DSIZE*chan_q +: DSIZE];
        term           = g_last || ((BURST != 0) && (cnt_q == BURST_LAST));
        hs             = xfer && g_vld && out_ready;
        out_vld        = xfer && g_vld;
        out_data       = xfer ? g_data : '0;
        out_last       = xfer && g_last && g_vld;
        out_align_last = xfer && term && g_vld;
        req_ready      = '0;
        if (xfer) begin
            req_ready[chan_q] = out_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|gnt_onehot) begin
                    chan_d  = gnt_idx;
                    ptr_d   = gnt_idx;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (hs) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    if (term) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer resets to NCH-1 so channel 0 holds top priority after reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= '0;
            ptr_q   <= PTR_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_chan = chan_q;
    assign busy     = xfer;

endmodule

// File: tb/tb_width_combin_arb.sv
// Directed bench for width_combin_arb: channel source queues drive the DUT,
// and an expected-beat scoreboard is checked on every output handshake.
module tb_width_combin_arb;

    localparam int NCH   = 4;
    localparam int DSIZE = 8;
    localparam int CSIZE = 2;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic [NCH*DSIZE-1:0] req_data;
    logic [NCH-1:0]       req_vld;
    logic [NCH-1:0]       req_last;
    logic                 out_ready;

    logic [NCH-1:0]   a_req_ready, b_req_ready, s_req_ready;
    logic [DSIZE-1:0] a_out_data, b_out_data, s_out_data;
    logic             a_out_vld, b_out_vld, s_out_vld;
    logic             a_out_last, b_out_last, s_out_last;
    logic             a_out_align, b_out_align, s_out_align;
    logic [CSIZE-1:0] a_out_chan, b_out_chan, s_out_chan;
    logic             a_busy, b_busy, s_busy;
    logic             use_b;

    width_combin_arb #(.NCH(NCH), .DSIZE(DSIZE), .BURST(0)) u_a (
        .clock(clock), .rst_n(rst_n), .req_data(req_data), .req_vld(req_vld),
        .req_last(req_last), .req_ready(a_req_ready), .out_data(a_out_data),
        .out_vld(a_out_vld), .out_ready(out_ready), .out_last(a_out_last),
        .out_align_last(a_out_align), .out_chan(a_out_chan), .busy(a_busy)
    );

    width_combin_arb #(.NCH(NCH), .DSIZE(DSIZE), .BURST(4)) u_b (
        .clock(clock), .rst_n(rst_n), .req_data(req_data), .req_vld(req_vld),
        .req_last(req_last), .req_ready(b_req_ready), .out_data(b_out_data),
        .out_vld(b_out_vld), .out_ready(out_ready), .out_last(b_out_last),
        .out_align_last(b_out_align), .out_chan(b_out_chan), .busy(b_busy)
    );

    assign s_req_ready = use_b ? b_req_ready : a_req_ready;
    assign s_out_data  = use_b ? b_out_data  : a_out_data;
    assign s_out_vld   = use_b ? b_out_vld   : a_out_vld;
    assign s_out_last  = use_b ? b_out_last  : a_out_last;
    assign s_out_align = use_b ? b_out_align : a_out_align;
    assign s_out_chan  = use_b ? b_out_chan  : a_out_chan;
    assign s_busy      = use_b ? b_busy      : a_busy;

    typedef struct packed {logic [7:0] data; logic last;} beat_t;
    typedef struct packed {logic [1:0] chan; logic [7:0] data; logic last; logic align;} exp_t;

    beat_t src_q[NCH][$];
    exp_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic  bubble_en;
    logic  rand_rdy;
    logic [NCH-1:0] stalled;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic src_pkt(input int ch, input int base, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = 8'(base + k);
            b.last = (k == n - 1);
            src_q[ch].push_back(b);
        end
    endtask

    task automatic exp_beat(input int ch, input int d, input logic last, input logic align);
        exp_t e;
        e.chan  = 2'(ch);
        e.data  = 8'(d);
        e.last  = last;
        e.align = align;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        logic have;
        for (int i = 0; i < NCH; i++) begin
            have = (src_q[i].size() > 0);
            req_vld[i] = have && (stalled[i] || !bubble_en || ($urandom_range(0, 1) == 1));
            req_data[DSIZE*i +: DSIZE] = have ? src_q[i][0].data : 8'h00;
            req_last[i] = have ? src_q[i][0].last : 1'b0;
        end
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic tick();
        logic [NCH-1:0] hs;
        exp_t e;
        drive();
        @(negedge clock);
        chk("req_ready", 32'(s_req_ready), s_busy ? 32'(NCH'(out_ready) << s_out_chan) : 32'd0);
        chk("out_vld", 32'(s_out_vld), 32'(s_busy && req_vld[s_out_chan]));
        hs = req_vld & s_req_ready;
        if (s_out_vld && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {22'd0, s_out_chan, s_out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("chan",  32'(s_out_chan),  32'(e.chan));
                chk("data",  32'(s_out_data),  32'(e.data));
                chk("last",  32'(s_out_last),  32'(e.last));
                chk("align", 32'(s_out_align), 32'(e.align));
            end
        end
        for (int i = 0; i < NCH; i++) begin
            stalled[i] = req_vld[i] && !hs[i];
            if (hs[i]) src_q[i].delete(0);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_until_empty(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_vld   = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        stalled   = '0;
        for (int i = 0; i < NCH; i++) src_q[i].delete();
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy",  32'(s_busy), 32'd0);
        chk("rst_chan",  32'(s_out_chan), 32'd0);
        chk("rst_vld",   32'(s_out_vld), 32'd0);
        chk("rst_ready", 32'(s_req_ready), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        use_b     = 1'b0;
        bubble_en = 1'b0;
        rand_rdy  = 1'b0;
        do_reset();

        // Idle: no requests for 20 cycles
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_vld",   32'(s_out_vld), 32'd0);
            chk("idle_busy",  32'(s_busy), 32'd0);
            chk("idle_ready", 32'(s_req_ready), 32'd0);
            chk("idle_flags", {30'd0, s_out_last, s_out_align}, 32'd0);
        end

        // Single 5-beat packet on channel 2
        do_reset();
        src_pkt(2, 'hA0, 5);
        for (int k = 0; k < 5; k++) exp_beat(2, 'hA0 + k, k == 4, k == 4);
        tick();
        chk("t1_busy", 32'(s_busy), 32'd1);
        chk("t1_chan", 32'(s_out_chan), 32'd2);
        run_until_empty(20);
        chk("t1_idle", 32'(s_busy), 32'd0);

        // All channels, two 2-beat packets each: round-robin, no interleave
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < NCH; c++) begin
                src_pkt(c, c * 16 + p * 2, 2);
                exp_beat(c, c * 16 + p * 2, 1'b0, 1'b0);
                exp_beat(c, c * 16 + p * 2 + 1, 1'b1, 1'b1);
            end
        end
        run_until_empty(100);

        // BURST=4 instance: 10-beat packet on ch1 split, ch3 served between splits
        use_b = 1'b1;
        do_reset();
        src_pkt(1, 'h10, 10);
        src_pkt(3, 'h30, 3);
        for (int k = 0; k < 4; k++) exp_beat(1, 'h10 + k, 1'b0, k == 3);
        for (int k = 0; k < 3; k++) exp_beat(3, 'h30 + k, k == 2, k == 2);
        for (int k = 4; k < 8; k++) exp_beat(1, 'h10 + k, 1'b0, k == 7);
        exp_beat(1, 'h18, 1'b0, 1'b0);
        exp_beat(1, 'h19, 1'b1, 1'b1);
        run_until_empty(100);
        use_b = 1'b0;

        // Random backpressure and source bubbles on ch0
        do_reset();
        bubble_en = 1'b1;
        rand_rdy  = 1'b1;
        src_pkt(0, 'hC0, 8);
        for (int k = 0; k < 8; k++) exp_beat(0, 'hC0 + k, k == 7, k == 7);
        run_until_empty(400);
        bubble_en = 1'b0;
        rand_rdy  = 1'b0;

        // Reset during beat 3 of a ch1 packet
        do_reset();
        src_pkt(1, 'h50, 6);
        exp_beat(1, 'h50, 1'b0, 1'b0);
        exp_beat(1, 'h51, 1'b0, 1'b0);
        run_until_empty(20);
        drive();
        #1;
        chk("t5_pre_vld",  32'(s_out_vld), 32'd1);
        chk("t5_pre_data", 32'(s_out_data), 32'h52);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld",   32'(s_out_vld), 32'd0);
        chk("t5_rst_busy",  32'(s_busy), 32'd0);
        chk("t5_rst_ready", 32'(s_req_ready), 32'd0);
        chk("t5_rst_flags", {30'd0, s_out_last, s_out_align}, 32'd0);
        chk("t5_rst_chan",  32'(s_out_chan), 32'd0);
        do_reset();
        src_pkt(3, 'h33, 1);
        src_pkt(0, 'h03, 1);
        exp_beat(0, 'h03, 1'b1, 1'b1);
        exp_beat(3, 'h33, 1'b1, 1'b1);
        run_until_empty(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
